// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
// Holds the sequencer state encoding and the counter width helper.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLL_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_t;

    // Counter must reach (largest cycle parameter - 1); never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs.
// Both stages clear asynchronously with reset_n.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings up an audio PLL: reset pulse, lock wait with retries, lock
// qualification, then releases the audio-clock consumers.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             clear_fault,
    input  logic                             pll_locked,
    output logic                             pll_rst,
    output logic                             audio_rst_n,
    output logic                             ready,
    output logic                             fault,
    output logic                             lock_lost,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES,
                                  LOCK_STABLE_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d, cnt_inc;
    logic [RW-1:0] retry_d;
    logic          locked_s;
    logic          pll_rst_d, audio_rst_n_d, ready_d, fault_d, lost_d;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (locked_s)
    );

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            retry_count <= '0;
            pll_rst     <= 1'b1;
            audio_rst_n <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            retry_count <= retry_d;
            pll_rst     <= pll_rst_d;
            audio_rst_n <= audio_rst_n_d;
            ready       <= ready_d;
            fault       <= fault_d;
            lock_lost   <= lost_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt_inc;
        retry_d = retry_count;
        if (!enable && state != S_FAULT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    state_d = S_PLL_RESET;
                    cnt_d   = '0;
                    retry_d = '0;
                end
                S_PLL_RESET: begin
                    if (cnt == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock is checked first so it wins over a same-cycle timeout.
                    if (locked_s) begin
                        state_d = S_STABLE;
                        cnt_d   = '0;
                    end else if (cnt == TMO_LAST) begin
                        cnt_d = '0;
                        if (retry_count < RTY_MAX) begin
                            state_d = S_PLL_RESET;
                            retry_d = retry_count + 1'b1;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt == STB_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    cnt_d = '0;
                    if (!locked_s) state_d = S_PLL_RESET;
                end
                S_FAULT: begin
                    cnt_d = '0;
                    if (clear_fault) begin
                        state_d = S_IDLE;
                        retry_d = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        pll_rst_d     = 1'b1;
        audio_rst_n_d = 1'b0;
        ready_d       = 1'b0;
        fault_d       = 1'b0;
        lost_d        = (state == S_RUN) && (state_d == S_PLL_RESET);
        case (state_d)
            S_WAIT_LOCK, S_STABLE: pll_rst_d = 1'b0;
            S_RUN: begin
                pll_rst_d     = 1'b0;
                audio_rst_n_d = 1'b1;
                ready_d       = 1'b1;
            end
            S_FAULT: fault_d = 1'b1;
            default: pll_rst_d = 1'b1;
        endcase
    end

endmodule
